// File: rtl/rx_symbol_aligner.sv
// Comma-based symbol aligner: locates the K28.5 boundary in unaligned deserializer words and
// emits aligned symbols plus a write strobe for the elastic buffer, all in the write_clk domain.
module rx_symbol_aligner #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned LOSS_CNT   = 2
) (
  input  logic                  write_clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  locked,
  output logic                  comma_det,
  output logic [3:0]            align_offset
);

  localparam int unsigned           WinWidth = 2 * DATA_WIDTH;
  localparam logic [3:0]            LockCntL = 4'(LOCK_CNT);
  localparam logic [3:0]            LossCntL = 4'(LOSS_CNT);
  localparam logic [DATA_WIDTH-1:0] K28p5Neg = DATA_WIDTH'(10'h17C);
  localparam logic [DATA_WIDTH-1:0] K28p5Pos = DATA_WIDTH'(10'h283);

  typedef enum logic [1:0] {StUnlocked, StAcquire, StLocked} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [3:0]            offset_q, offset_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  locked_q, locked_d;
  logic                  comma_det_q, comma_det_d;

  logic [WinWidth-1:0]   window;
  logic [DATA_WIDTH-1:0] cand [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] comma_hit;
  logic                  hit_any;
  logic                  hit_cur;
  logic [3:0]            hit_k;
  logic [3:0]            sel_off;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // prev_q holds the older word, so bit 0 of the window is the earliest received bit.
  assign window = {data_in, prev_q};

  always_comb begin
    for (int k = 0; k < DATA_WIDTH; k++) begin
      cand[k]      = window[k +: DATA_WIDTH];
      comma_hit[k] = (cand[k][6:0] == 7'b1111100) || (cand[k][6:0] == 7'b0000011);
    end
  end

  // Lowest matching offset wins.
  always_comb begin
    hit_any = 1'b0;
    hit_k   = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      if (comma_hit[k] && !hit_any) begin
        hit_any = 1'b1;
        hit_k   = 4'(k);
      end
    end
  end

  assign hit_cur = comma_hit[offset_q];

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    sel_off  = offset_q;

    if (!rx_valid) begin
      state_d = StUnlocked;
      cnt_d   = '0;
      err_d   = '0;
    end else begin
      unique case (state_q)
        StUnlocked: begin
          if (hit_any) begin
            offset_d = hit_k;
            sel_off  = hit_k;
            cnt_d    = 4'd1;
            err_d    = '0;
            state_d  = (LockCntL <= 4'd1) ? StLocked : StAcquire;
          end
        end
        StAcquire: begin
          if (hit_cur) begin
            cnt_d = sat_inc(cnt_q);
            if (cnt_d >= LockCntL) begin
              state_d = StLocked;
              err_d   = '0;
            end
          end else if (hit_any) begin
            offset_d = hit_k;
            sel_off  = hit_k;
            cnt_d    = 4'd1;
          end
        end
        StLocked: begin
          if (hit_cur) begin
            err_d = '0;
          end else if (hit_any) begin
            err_d = sat_inc(err_q);
            if (err_d >= LossCntL) begin
              state_d = StUnlocked;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = StUnlocked;
        end
      endcase
    end

    data_out_d  = cand[sel_off];
    comma_det_d = (data_out_d == K28p5Neg) || (data_out_d == K28p5Pos);
    locked_d    = (state_d == StLocked);
  end

  always_ff @(posedge write_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StUnlocked;
      prev_q      <= '0;
      offset_q    <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      data_out_q  <= '0;
      locked_q    <= 1'b0;
      comma_det_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= data_in;
      offset_q    <= offset_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      data_out_q  <= data_out_d;
      locked_q    <= locked_d;
      comma_det_q <= comma_det_d;
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = locked_q;
  assign locked       = locked_q;
  assign comma_det    = comma_det_q;
  assign align_offset = offset_q;

endmodule

// File: tb/tb_rx_symbol_aligner.sv
// Directed bench for rx_symbol_aligner: builds a serial bit stream of symbols at chosen bit
// offsets, chops it into words and scoreboards the aligned output of each word.
module tb_rx_symbol_aligner;

  localparam logic [9:0] KN = 10'h17C;  // K28.5 RD-
  localparam logic [9:0] KP = 10'h283;  // K28.5 RD+
  localparam logic [9:0] DA = 10'h155;  // D21.5
  localparam logic [9:0] DB = 10'h2AA;  // D10.2

  logic       write_clk;
  logic       rst_n;
  logic       rx_valid;
  logic [9:0] data_in;
  logic [9:0] data_out;
  logic       data_valid;
  logic       locked;
  logic       comma_det;
  logic [3:0] align_offset;

  int errors;
  int checks;

  typedef struct {
    int         pos;
    logic [9:0] sym;
    logic       lk;
    logic [3:0] off;
    logic       chk;
    logic       rv;
  } exp_t;

  exp_t pend_q[$];  // symbols placed in the stream, waiting for their window
  exp_t sb_q[$];    // expectation for the word currently being driven
  logic bitq[$];
  int   nbits;
  int   nwords;
  logic last_bit;
  logic cur_lock;
  logic [3:0] cur_off;

  rx_symbol_aligner #(
    .DATA_WIDTH(10),
    .LOCK_CNT  (3),
    .LOSS_CNT  (2)
  ) dut (
    .write_clk   (write_clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .locked      (locked),
    .comma_det   (comma_det),
    .align_offset(align_offset)
  );

  initial begin
    write_clk = 1'b0;
    forever #5 write_clk = ~write_clk;
  end

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data_out"}, data_out, 10'h000);
    check({tag, "_data_valid"}, 10'(data_valid), 10'h000);
    check({tag, "_locked"}, 10'(locked), 10'h000);
    check({tag, "_comma_det"}, 10'(comma_det), 10'h000);
    check({tag, "_offset"}, 10'(align_offset), 10'h000);
  endtask

  task automatic add_bit(input logic b);
    bitq.push_back(b);
    nbits++;
    last_bit = b;
  endtask

  // Alternating filler bits never form a 5-bit run, so they cannot create a false comma.
  task automatic add_slip(input int n);
    for (int i = 0; i < n; i++) add_bit(~last_bit);
  endtask

  task automatic add_sym(input logic [9:0] s, input logic lk, input logic [3:0] off,
                         input logic chk, input logic rv);
    exp_t e;
    e.pos = nbits;
    e.sym = s;
    e.lk  = lk;
    e.off = off;
    e.chk = chk;
    e.rv  = rv;
    pend_q.push_back(e);
    for (int i = 0; i < 10; i++) add_bit(s[i]);
  endtask

  task automatic step();
    exp_t       e;
    logic [9:0] w;
    int         wi;
    while (bitq.size() < 10) add_slip(1);
    for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
    wi = nwords;
    nwords++;
    // A symbol starting at bit p is visible once the word after the one holding p arrives.
    if (pend_q.size() > 0 && pend_q[0].pos < 10 * wi) begin
      e = pend_q.pop_front();
      cur_lock = e.lk;
      cur_off  = e.off;
    end else begin
      e.pos = -1;
      e.sym = '0;
      e.lk  = cur_lock;
      e.off = cur_off;
      e.chk = 1'b0;
      e.rv  = 1'b1;
    end
    data_in  = w;
    rx_valid = e.rv;
    sb_q.push_back(e);
    @(posedge write_clk);
    #1;
    e = sb_q.pop_front();
    check($sformatf("locked@w%0d", wi), 10'(locked), 10'(e.lk));
    check($sformatf("data_valid@w%0d", wi), 10'(data_valid), 10'(e.lk));
    check($sformatf("offset@w%0d", wi), 10'(align_offset), 10'(e.off));
    if (e.chk) begin
      check($sformatf("data_out@w%0d", wi), data_out, e.sym);
      check($sformatf("comma_det@w%0d", wi), 10'(comma_det), 10'((e.sym == KN) || (e.sym == KP)));
    end
  endtask

  logic [19:0] mwin;

  initial begin
    errors   = 0;
    checks   = 0;
    nbits    = 0;
    nwords   = 0;
    last_bit = 1'b0;
    cur_lock = 1'b0;
    cur_off  = 4'd0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    data_in  = '0;

    // Reset held while inputs toggle.
    for (int i = 0; i < 3; i++) begin
      data_in  = 10'($urandom);
      rx_valid = 1'($urandom);
      @(posedge write_clk);
      #1;
      check_zero($sformatf("reset_hold%0d", i));
    end
    rst_n = 1'b1;

    // Acquisition at offset 3.
    add_slip(3);
    add_sym(KN, 0, 3, 1, 1);
    add_sym(DA, 0, 3, 1, 1);
    add_sym(KP, 0, 3, 1, 1);
    add_sym(DB, 0, 3, 1, 1);
    add_sym(KN, 1, 3, 1, 1);
    add_sym(DA, 1, 3, 1, 1);
    add_sym(KP, 1, 3, 1, 1);
    add_sym(DB, 1, 3, 1, 1);
    // One misaligned comma is tolerated, then an aligned comma clears the error count.
    add_slip(2);
    add_sym(KN, 1, 3, 0, 1);
    add_slip(8);
    add_sym(KP, 1, 3, 1, 1);
    add_sym(DA, 1, 3, 1, 1);
    // Two consecutive misaligned commas drop lock; reacquire at offset 5.
    add_slip(2);
    add_sym(KN, 1, 3, 0, 1);
    add_sym(KP, 0, 3, 0, 1);
    add_sym(DA, 0, 3, 0, 1);
    add_sym(KN, 0, 5, 1, 1);
    add_sym(DB, 0, 5, 1, 1);
    add_sym(KP, 0, 5, 1, 1);
    add_sym(DA, 0, 5, 1, 1);
    add_sym(KN, 1, 5, 1, 1);
    add_sym(DB, 1, 5, 1, 1);
    // rx_valid drop for one word forces a full reacquisition.
    add_sym(DA, 0, 5, 0, 0);
    add_sym(KN, 0, 5, 1, 1);
    add_sym(DB, 0, 5, 1, 1);
    add_sym(KP, 0, 5, 1, 1);
    add_sym(DA, 0, 5, 1, 1);
    add_sym(KN, 1, 5, 1, 1);
    add_sym(DB, 1, 5, 1, 1);
    // Drop again, then two commas at offset 3 followed by an offset change to 7 in ACQUIRE.
    add_sym(DA, 0, 5, 0, 0);
    add_slip(8);
    add_sym(KP, 0, 3, 1, 1);
    add_sym(DA, 0, 3, 1, 1);
    add_sym(KN, 0, 3, 1, 1);
    add_sym(DB, 0, 3, 1, 1);
    add_slip(4);
    add_sym(KP, 0, 7, 1, 1);
    add_sym(DA, 0, 7, 1, 1);
    add_sym(KN, 0, 7, 1, 1);
    add_sym(DB, 0, 7, 1, 1);
    add_sym(KP, 1, 7, 1, 1);
    add_sym(DA, 1, 7, 1, 1);

    while (pend_q.size() > 0) step();
    check("locked_before_async_reset", 10'(locked), 10'h001);

    // Asynchronous reset mid-lock, checked before the next clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(posedge write_clk);
    #2;
    rst_n    = 1'b1;
    rx_valid = 1'b1;

    // Window with comma patterns at k=2 (RD-) and k=8 (RD+): lowest wins.
    mwin    = {10'h2A0, 10'h3F1};
    data_in = mwin[9:0];
    @(posedge write_clk);
    #1;
    check("multi_pre_offset", 10'(align_offset), 10'h000);
    data_in = mwin[19:10];
    @(posedge write_clk);
    #1;
    check("multi_offset", 10'(align_offset), 10'h002);
    check("multi_data_out", data_out, mwin[11:2]);
    check("multi_locked", 10'(locked), 10'h000);
    check("multi_comma_det", 10'(comma_det), 10'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
